mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencing controller for the MIPS datapath (regfile, ALU, sign-extend, data memory, PC muxes). It replaces single-cycle decode: it registers a state per instruction phase and drives the datapath enables and mux selects from that state. It stalls on a memory ready handshake, traps illegal opcodes, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
RESET_PC_HOLD, 1, idle cycles spent in S_RESET after reset deasserts (1..3)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  instruction[31:26], valid from S_DECODE onward (IR already latched)
funct  in  6  instruction[5:0]
zero  in  1  ALU zero flag from the current cycle's ALU operation
mem_ready  in  1  memory handshake; access completes in a cycle where mem_req=1 and mem_ready=1
mem_req  out  1  memory access request
mem_write  out  1  store strobe (qualified by mem_ready)
ir_write  out  1  latch instruction register
pc_write  out  1  PC update enable
pc_src  out  2  00 PC+4, 01 branch target, 10 jump {PC[31:28],addr,00}, 11 Da (JR)
reg_write  out  1  regfile write enable
reg_dst  out  2  00 rt, 01 rd, 10 r31
wb_src  out  2  00 ALU result, 01 memory data, 10 PC+4
alu_src_b  out  1  0 Db, 1 sign-extended immediate
alu_op  out  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
illegal  out  1  sticky trap flag
retired  out  CNT_W  retired-instruction count
state  out  4  current state (debug)

Behaviour:
- State register updates on rising clk; all outputs are Moore-decoded from state, except pc_write in S_BRANCH and the mem_ready-qualified strobes.
- On reset=1: next state S_RESET, retired=0, illegal=0. In S_RESET every strobe (mem_req, mem_write, ir_write, pc_write, reg_write) is 0 and every select is 0. Reset taken mid-instruction aborts it; no write strobe asserts in the reset cycle or the following S_RESET cycles.
- S_RESET holds RESET_PC_HOLD cycles, then goes to S_FETCH.
- S_FETCH: mem_req=1. Stay while mem_ready=0, with ir_write and pc_write held at 0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, then go to S_DECODE.
- S_DECODE decodes op/funct:
  - LW 0x23, SW 0x2B go to S_MEM_ADDR.
  - op 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A go to S_EXEC_R.
  - op 0x00 with funct JR 0x08 goes to S_JR.
  - ADDI 0x08, XORI 0x0E go to S_EXEC_I.
  - BEQ 0x04, BNE 0x05 go to S_BRANCH.
  - J 0x02 goes to S_JUMP. JAL 0x03 goes to S_JAL.
  - Anything else goes to S_TRAP.
- S_EXEC_R: alu_src_b=0, alu_op from funct (ADD 000, SUB 001, SLT 011); next S_WB_R.
- S_WB_R: reg_write=1, reg_dst=01, wb_src=00; retire; next S_FETCH.
- S_EXEC_I: alu_src_b=1, alu_op ADD (ADDI) or XOR (XORI); next S_WB_I.
- S_WB_I: reg_write=1, reg_dst=00, wb_src=00; retire; next S_FETCH.
- S_MEM_ADDR: alu_src_b=1, alu_op=ADD; next S_MEM_RD (LW) or S_MEM_WR (SW).
- S_MEM_RD: mem_req=1; stall while !mem_ready; then S_WB_MEM.
- S_WB_MEM: reg_write=1, reg_dst=00, wb_src=01; retire; next S_FETCH.
- S_MEM_WR: mem_req=1, mem_write=mem_ready; stall while !mem_ready; on completion retire and go to S_FETCH.
- S_BRANCH: alu_src_b=0, alu_op=SUB, pc_src=01. pc_write = (BEQ & zero) | (BNE & ~zero). Retire; next S_FETCH.
- S_JUMP: pc_write=1, pc_src=10; retire; next S_FETCH.
- S_JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, wb_src=10 (PC+4 already in PC reg path), all in the same cycle; retire; next S_FETCH.
- S_JR: pc_write=1, pc_src=11; retire; next S_FETCH.
- S_TRAP: illegal=1, sticky. All strobes 0. Remains in S_TRAP until reset.
- Latency with mem_ready tied 1 (cycles FETCH to retire): R/I=4, LW=5, SW=4, BEQ/BNE/J/JAL/JR=3. Each stall cycle adds 1.
- retired increments by exactly 1 in the retire cycle, wraps modulo 2^CNT_W, never increments in S_TRAP or S_RESET.
- Reset has priority over every transition, including a simultaneous mem_ready completion.

Decomposition:
- Package mips_ctrl_pkg: state encodings (4-bit localparams), opcode/funct constants, alu_op codes, pc_src/reg_dst/wb_src encodings.
- One natural sub-module, mips_ctrl_decode: combinational map from (state, op, funct, zero, mem_ready) to the output bundle. The top keeps the state register, reset-hold counter, retired counter and trap flag.

Test Plan:
- Reset, mem_ready=1, ADD (op 0, funct 0x20) -> FETCH, DECODE, EXEC_R, WB_R; reg_write=1 with reg_dst=01 only in cycle 4; retired 0 -> 1.
- LW with mem_ready low for 3 cycles in MEM_RD -> state holds MEM_RD for 4 cycles, reg_write=0 during the stall, WB_MEM at cycle 8, wb_src=01.
- BEQ with zero=1, then BNE with zero=1 -> first asserts pc_write=1, pc_src=01 in BRANCH; second keeps pc_write=0; both retire (count +2).
- JAL -> single S_JAL cycle with pc_write=1, pc_src=10, reg_write=1, reg_dst=10, wb_src=10.
- op=0x3F -> S_TRAP, illegal=1 held for 20 cycles with no strobes; reset clears illegal=0, retired=0, then S_RESET, then S_FETCH.
- Preload retired=2^CNT_W-1 (CNT_W=4 build) and retire one instruction -> retired=0; reset asserted during S_MEM_WR with mem_ready=1 -> mem_write=0 that cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the MIPS multi-cycle controller
//
// Purpose: state encodings, opcode/funct constants, datapath select codes,
//          the control bundle struct and the S_DECODE dispatch function.
// Ports:   none (package).
package mips_ctrl_pkg;

  // FSM state encodings (all 16 codes of the 4-bit state register are used)
  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_WB_R     = 4'd4;
  localparam logic [3:0] S_EXEC_I   = 4'd5;
  localparam logic [3:0] S_WB_I     = 4'd6;
  localparam logic [3:0] S_MEM_ADDR = 4'd7;
  localparam logic [3:0] S_MEM_RD   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_MEM_WR   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [3:0] S_JAL      = 4'd13;
  localparam logic [3:0] S_JR       = 4'd14;
  localparam logic [3:0] S_TRAP     = 4'd15;

  // Primary opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instruction[5:0]
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  // PC source select
  localparam logic [1:0] PCS_PLUS4  = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_JR     = 2'b11;

  // Register destination select
  localparam logic [1:0] RDS_RT  = 2'b00;
  localparam logic [1:0] RDS_RD  = 2'b01;
  localparam logic [1:0] RDS_R31 = 2'b10;

  // Write-back source select
  localparam logic [1:0] WBS_ALU = 2'b00;
  localparam logic [1:0] WBS_MEM = 2'b01;
  localparam logic [1:0] WBS_PC4 = 2'b10;

  // Datapath control bundle produced by the decoder each cycle
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       alu_src_b;
    logic [2:0] alu_op;
  } ctrl_t;

  // Successor of S_DECODE; anything not recognised lands in S_TRAP
  function automatic logic [3:0] decode_target(input logic [5:0] op,
                                               input logic [5:0] funct);
    logic [3:0] t;
    t = S_TRAP;
    case (op)
      OP_LW, OP_SW:     t = S_MEM_ADDR;
      OP_ADDI, OP_XORI: t = S_EXEC_I;
      OP_BEQ, OP_BNE:   t = S_BRANCH;
      OP_J:             t = S_JUMP;
      OP_JAL:           t = S_JAL;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: t = S_EXEC_R;
          FN_JR:                  t = S_JR;
          default:                t = S_TRAP;
        endcase
      end
      default:          t = S_TRAP;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational state-to-control decoder
//
// Purpose: maps the current state plus IR fields and handshakes onto the
//          datapath control bundle, the natural next state and a retire pulse.
// Ports:   i_state     current FSM state
//          i_op        instruction[31:26]
//          i_funct     instruction[5:0]
//          i_zero      ALU zero flag
//          i_mem_ready memory handshake
//          o_ctrl      datapath strobes and selects
//          o_next      next state ignoring reset and reset-hold
//          o_retire    instruction completes this cycle
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl,
  output logic [3:0] o_next,
  output logic       o_retire
);

  always_comb begin
    o_ctrl   = '0;
    o_next   = i_state;
    o_retire = 1'b0;
    case (i_state)
      S_RESET: o_next = S_FETCH;

      S_FETCH: begin
        o_ctrl.mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ctrl.ir_write = 1'b1;
          o_ctrl.pc_write = 1'b1;
          o_ctrl.pc_src   = PCS_PLUS4;
          o_next          = S_DECODE;
        end
      end

      S_DECODE: o_next = decode_target(i_op, i_funct);

      S_EXEC_R: begin
        o_ctrl.alu_src_b = 1'b0;
        case (i_funct)
          FN_SUB:  o_ctrl.alu_op = ALU_SUB;
          FN_SLT:  o_ctrl.alu_op = ALU_SLT;
          default: o_ctrl.alu_op = ALU_ADD;
        endcase
        o_next = S_WB_R;
      end

      S_WB_R: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = RDS_RD;
        o_ctrl.wb_src    = WBS_ALU;
        o_retire         = 1'b1;
        o_next           = S_FETCH;
      end

      S_EXEC_I: begin
        o_ctrl.alu_src_b = 1'b1;
        o_ctrl.alu_op    = (i_op == OP_XORI) ? ALU_XOR : ALU_ADD;
        o_next           = S_WB_I;
      end

      S_WB_I: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = RDS_RT;
        o_ctrl.wb_src    = WBS_ALU;
        o_retire         = 1'b1;
        o_next           = S_FETCH;
      end

      S_MEM_ADDR: begin
        o_ctrl.alu_src_b = 1'b1;
        o_ctrl.alu_op    = ALU_ADD;
        o_next           = (i_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        o_ctrl.mem_req = 1'b1;
        if (i_mem_ready) o_next = S_WB_MEM;
      end

      S_WB_MEM: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = RDS_RT;
        o_ctrl.wb_src    = WBS_MEM;
        o_retire         = 1'b1;
        o_next           = S_FETCH;
      end

      S_MEM_WR: begin
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.mem_write = i_mem_ready;
        if (i_mem_ready) begin
          o_retire = 1'b1;
          o_next   = S_FETCH;
        end
      end

      S_BRANCH: begin
        o_ctrl.alu_src_b = 1'b0;
        o_ctrl.alu_op    = ALU_SUB;
        o_ctrl.pc_src    = PCS_BRANCH;
        // Only the taken direction updates PC; PC already holds PC+4 otherwise
        o_ctrl.pc_write  = ((i_op == OP_BEQ) &  i_zero) |
                           ((i_op == OP_BNE) & ~i_zero);
        o_retire         = 1'b1;
        o_next           = S_FETCH;
      end

      S_JUMP: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PCS_JUMP;
        o_retire        = 1'b1;
        o_next          = S_FETCH;
      end

      S_JAL: begin
        // PC still holds PC+4 this cycle, so link and jump share one cycle
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_src    = PCS_JUMP;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = RDS_R31;
        o_ctrl.wb_src    = WBS_PC4;
        o_retire         = 1'b1;
        o_next           = S_FETCH;
      end

      S_JR: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PCS_JR;
        o_retire        = 1'b1;
        o_next          = S_FETCH;
      end

      S_TRAP: o_next = S_TRAP;

      default: o_next = S_RESET;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle sequencing controller for the MIPS datapath
//
// Purpose: holds the phase state register, reset-hold counter, retired
//          instruction counter and sticky illegal flag; drives datapath
//          strobes and selects through mips_ctrl_decode.
// Ports:   i_clk, i_reset   clock, synchronous active-high reset
//          i_op, i_funct    latched instruction fields
//          i_zero           ALU zero flag
//          i_mem_ready      memory handshake
//          o_mem_req, o_mem_write, o_ir_write, o_pc_write, o_reg_write  strobes
//          o_pc_src, o_reg_dst, o_wb_src, o_alu_src_b, o_alu_op         selects
//          o_illegal        sticky trap flag
//          o_retired        retired-instruction count
//          o_state          current state (debug)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [5:0]       i_op,
  input  logic [5:0]       i_funct,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic [1:0]       o_pc_src,
  output logic             o_reg_write,
  output logic [1:0]       o_reg_dst,
  output logic [1:0]       o_wb_src,
  output logic             o_alu_src_b,
  output logic [2:0]       o_alu_op,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired,
  output logic [3:0]       o_state
);

  localparam logic [1:0]       HOLD_LAST = 2'(RESET_PC_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       r_state;
  logic [1:0]       r_hold;
  logic [CNT_W-1:0] r_retired;
  logic             r_illegal;

  ctrl_t      w_ctrl;
  logic [3:0] w_next;
  logic [3:0] w_state_d;
  logic       w_retire;
  logic       w_hold_done;
  logic       w_strobe_en;

  mips_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_op        (i_op),
    .i_funct     (i_funct),
    .i_zero      (i_zero),
    .i_mem_ready (i_mem_ready),
    .o_ctrl      (w_ctrl),
    .o_next      (w_next),
    .o_retire    (w_retire)
  );

  assign w_hold_done = (r_hold == HOLD_LAST);

  // S_RESET lingers until the hold counter has covered RESET_PC_HOLD cycles
  assign w_state_d = ((r_state == S_RESET) && !w_hold_done) ? S_RESET : w_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_RESET;
      r_hold    <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == S_RESET) && !w_hold_done) begin
        r_hold <= r_hold + 2'd1;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_ONE;
      end
      if (w_state_d == S_TRAP) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Reset aborts the in-flight instruction: no write strobe may leak out in
  // the reset cycle even if the decoder sees a completing handshake.
  assign w_strobe_en = ~i_reset;

  assign o_mem_req   = w_ctrl.mem_req   & w_strobe_en;
  assign o_mem_write = w_ctrl.mem_write & w_strobe_en;
  assign o_ir_write  = w_ctrl.ir_write  & w_strobe_en;
  assign o_pc_write  = w_ctrl.pc_write  & w_strobe_en;
  assign o_reg_write = w_ctrl.reg_write & w_strobe_en;
  assign o_pc_src    = w_ctrl.pc_src;
  assign o_reg_dst   = w_ctrl.reg_dst;
  assign o_wb_src    = w_ctrl.wb_src;
  assign o_alu_src_b = w_ctrl.alu_src_b;
  assign o_alu_op    = w_ctrl.alu_op;
  assign o_illegal   = r_illegal;
  assign o_retired   = r_retired;
  assign o_state     = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard testbench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic          zero;
  logic          mem_ready;
  logic          mem_req, mem_write, ir_write, pc_write, reg_write;
  logic [1:0]    pc_src, reg_dst, wb_src;
  logic          alu_src_b;
  logic [2:0]    alu_op;
  logic          illegal;
  logic [CW-1:0] retired;
  logic [3:0]    state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CW), .RESET_PC_HOLD(1)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_op        (op),
    .i_funct     (funct),
    .i_zero      (zero),
    .i_mem_ready (mem_ready),
    .o_mem_req   (mem_req),
    .o_mem_write (mem_write),
    .o_ir_write  (ir_write),
    .o_pc_write  (pc_write),
    .o_pc_src    (pc_src),
    .o_reg_write (reg_write),
    .o_reg_dst   (reg_dst),
    .o_wb_src    (wb_src),
    .o_alu_src_b (alu_src_b),
    .o_alu_op    (alu_op),
    .o_illegal   (illegal),
    .o_retired   (retired),
    .o_state     (state)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic [4:0]    sb;
    logic [1:0]    ps;
    logic [1:0]    rd;
    logic [1:0]    wb;
    logic          asb;
    logic [2:0]    ao;
    logic          il;
    logic [CW-1:0] rt;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  obs_t  act;
  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_queued = 0;

  always_comb act = {state, mem_req, mem_write, ir_write, pc_write, reg_write,
                     pc_src, reg_dst, wb_src, alu_src_b, alu_op, illegal, retired};

  always @(negedge clk) begin
    obs_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_chk++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got st=%0d sb=%b ps=%b rd=%b wb=%b asb=%b alu=%b ill=%b ret=%0d | want st=%0d sb=%b ps=%b rd=%b wb=%b asb=%b alu=%b ill=%b ret=%0d",
                    nm, act.st, act.sb, act.ps, act.rd, act.wb, act.asb, act.ao, act.il, act.rt,
                    e.st, e.sb, e.ps, e.rd, e.wb, e.asb, e.ao, e.il, e.rt);
    end
  end

  task automatic cyc(input string nm, input logic [3:0] st, input logic [4:0] sb,
                     input logic [1:0] ps, input logic [1:0] rd, input logic [1:0] wb,
                     input logic asb, input logic [2:0] ao, input logic il, input int rt);
    obs_t e;
    e.st = st; e.sb = sb; e.ps = ps; e.rd = rd; e.wb = wb;
    e.asb = asb; e.ao = ao; e.il = il; e.rt = CW'(rt);
    exp_q.push_back(e);
    name_q.push_back(nm);
    n_queued++;
    @(posedge clk);
    #1;
  endtask

  task automatic hd(input int rt);
    cyc("fetch",  S_FETCH,  5'b10110, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, rt);
    cyc("decode", S_DECODE, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, rt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst_active", S_RESET, 5'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 0);
    reset = 1'b0;
    cyc("rst_hold",   S_RESET, 5'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 0);

    op = 6'h00; funct = 6'h20;
    hd(0);
    cyc("add_exec", S_EXEC_R, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 0);
    cyc("add_wb",   S_WB_R,   5'b00001, 2'b00, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 0);

    op = 6'h23;
    hd(1);
    cyc("lw_addr", S_MEM_ADDR, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1);
    mem_ready = 1'b0;
    repeat (3) cyc("lw_stall", S_MEM_RD, 5'b10000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1);
    mem_ready = 1'b1;
    cyc("lw_done", S_MEM_RD, 5'b10000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1);
    cyc("lw_wb",   S_WB_MEM, 5'b00001, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 1'b0, 1);

    op = 6'h04; zero = 1'b1;
    hd(2);
    cyc("beq_taken", S_BRANCH, 5'b00010, 2'b01, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 2);
    op = 6'h05;
    hd(3);
    cyc("bne_not",   S_BRANCH, 5'b00000, 2'b01, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 3);
    zero = 1'b0;
    hd(4);
    cyc("bne_taken", S_BRANCH, 5'b00010, 2'b01, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 4);

    op = 6'h03;
    hd(5);
    cyc("jal", S_JAL, 5'b00011, 2'b10, 2'b10, 2'b10, 1'b0, 3'b000, 1'b0, 5);

    op = 6'h2B; mem_ready = 1'b0;
    cyc("sw_fstall", S_FETCH, 5'b10000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 6);
    mem_ready = 1'b1;
    hd(6);
    cyc("sw_addr", S_MEM_ADDR, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 6);
    mem_ready = 1'b0;
    cyc("sw_wstall", S_MEM_WR, 5'b10000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 6);
    mem_ready = 1'b1;
    cyc("sw_wr",     S_MEM_WR, 5'b11000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 6);

    op = 6'h02;
    hd(7);
    cyc("j",  S_JUMP, 5'b00010, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 7);
    op = 6'h00; funct = 6'h08;
    hd(8);
    cyc("jr", S_JR,   5'b00010, 2'b11, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 8);

    op = 6'h08;
    hd(9);
    cyc("addi_exec", S_EXEC_I, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 9);
    cyc("addi_wb",   S_WB_I,   5'b00001, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 9);
    op = 6'h0E;
    hd(10);
    cyc("xori_exec", S_EXEC_I, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 3'b010, 1'b0, 10);
    cyc("xori_wb",   S_WB_I,   5'b00001, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 10);

    op = 6'h00; funct = 6'h22;
    hd(11);
    cyc("sub_exec", S_EXEC_R, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 11);
    cyc("sub_wb",   S_WB_R,   5'b00001, 2'b00, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 11);
    funct = 6'h2A;
    hd(12);
    cyc("slt_exec", S_EXEC_R, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b011, 1'b0, 12);
    cyc("slt_wb",   S_WB_R,   5'b00001, 2'b00, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 12);

    op = 6'h02;
    for (int i = 13; i <= 15; i++) begin
      hd(i);
      cyc("j_cnt", S_JUMP, 5'b00010, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, i);
    end

    op = 6'h2B;
    cyc("wrap_fetch", S_FETCH, 5'b10110, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 0);
    cyc("decode",     S_DECODE, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 0);
    cyc("sw2_addr",   S_MEM_ADDR, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 0);
    reset = 1'b1;
    cyc("sw_rst",     S_MEM_WR, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 0);
    reset = 1'b0;
    cyc("sw_rst_nxt", S_RESET,  5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 0);

    op = 6'h02;
    hd(0);
    cyc("j_pre", S_JUMP, 5'b00010, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 0);

    op = 6'h3F;
    hd(1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      zero      = i[1];
      cyc("trap_hold", S_TRAP, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1, 1);
    end
    mem_ready = 1'b1; zero = 1'b0;
    reset = 1'b1;
    cyc("trap_rst",   S_TRAP,  5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1, 1);
    reset = 1'b0;
    cyc("trap_clear", S_RESET, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 0);

    op = 6'h00; funct = 6'h01;
    hd(0);
    cyc("rtype_trap", S_TRAP, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1, 0);

    @(posedge clk);
    #1;
    if (n_chk != n_queued)
      $display("FAIL monitor: %0d checks run, %0d queued", n_chk, n_queued);
    if (n_pass != n_chk)
      $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
    if (illegal !== 1'b1)
      $display("FAIL sticky: illegal=%b after final trap", illegal);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
